// File: rtl/bf_compiler_pkg.sv
// bf_compiler_pkg: opcode fields, error causes, command characters and FSM states
// shared by the Brainfuck compiler and its bracket stack.
package bf_compiler_pkg;
    localparam int DEF_CADDR_WIDTH = 13;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [7:0] OP_BR   = 8'h80;
    localparam logic [2:0] OP_LJ   = 3'b101;
    localparam logic [7:0] OP_IN   = 8'hC0;
    localparam logic [7:0] OP_OUT  = 8'hE0;

    localparam logic [1:0] ERR_UNMATCHED = 2'd1;
    localparam logic [1:0] ERR_UNCLOSED  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

    localparam logic [7:0] CH_INC   = "+";
    localparam logic [7:0] CH_DEC   = "-";
    localparam logic [7:0] CH_RIGHT = ">";
    localparam logic [7:0] CH_LEFT  = "<";
    localparam logic [7:0] CH_LB    = "[";
    localparam logic [7:0] CH_RB    = "]";
    localparam logic [7:0] CH_IN    = ",";
    localparam logic [7:0] CH_OUT   = ".";

    typedef enum logic [3:0] {
        ACCEPT, FLUSH, OPEN_HI, OPEN_LO, CLOSE, PATCH_HI, PATCH_LO, EMIT_IO, FINISH, DONE, ERROR
    } state_t;

    function automatic logic is_run(input logic [7:0] b);
        return b == CH_INC || b == CH_DEC || b == CH_RIGHT || b == CH_LEFT;
    endfunction

    function automatic logic is_add(input logic [7:0] b);
        return b == CH_INC || b == CH_DEC;
    endfunction

    function automatic logic signed [5:0] run_delta(input logic [7:0] b);
        return (b == CH_INC || b == CH_RIGHT) ? 6'sd1 : -6'sd1;
    endfunction

    // Where a byte goes once any pending run has been written out.
    function automatic state_t target(input logic [7:0] b, input logic last);
        return b == CH_LB ? OPEN_HI : b == CH_RB ? CLOSE :
               (b == CH_IN || b == CH_OUT) ? EMIT_IO : last ? FINISH : ACCEPT;
    endfunction
endpackage

// File: rtl/bf_compiler_stack.sv
// bf_compiler_stack: LIFO of open-bracket addresses, 2^DEPTH entries deep.
module bf_compiler_stack #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [2**DEPTH];
    logic [DEPTH:0]   sp;
    logic [DEPTH:0]   spm;

    assign spm   = sp - 1'b1;
    assign top   = mem[spm[DEPTH-1:0]];
    assign empty = sp == '0;
    assign full  = sp[DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push) begin
            mem[sp[DEPTH-1:0]] <= din;
            sp <= sp + 1'b1;
        end else if (pop) begin
            sp <= spm;
        end
    end
endmodule

// File: rtl/bf_compiler.sv
// bf_compiler: run-length encodes Brainfuck source into packed instructions,
// writing code RAM and back-patching long-jump offsets when each ']' arrives.
module bf_compiler
    import bf_compiler_pkg::*;
#(
    parameter int CADDR_WIDTH = DEF_CADDR_WIDTH,
    parameter int SAW = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   code_wr,
    output logic [CADDR_WIDTH-1:0] code_waddr,
    output logic [7:0]             code_wdata,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code,
    output logic [CADDR_WIDTH:0]   prog_len
);
    state_t                  state, nstate;
    logic [7:0]              cur;
    logic                    last_r, kind, live;
    logic signed [5:0]       cnt, d_in;
    logic [6:0]              sum;
    logic                    accept, run_break, cmd_in, ovf, patch, wr_req;
    logic [CADDR_WIDTH-1:0]  pa, poff, addr, top;
    logic [7:0]              data;
    logic                    push, pop, empty, full;
    state_t                  fin;

    bf_compiler_stack #(.WIDTH(CADDR_WIDTH), .DEPTH(SAW)) u_stack (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .din(prog_len[CADDR_WIDTH-1:0]), .top(top), .empty(empty), .full(full)
    );

    assign accept    = in_valid && in_ready;
    assign d_in      = run_delta(in_data);
    assign sum       = {cnt[5], cnt} + {d_in[5], d_in};
    // A pending run must be written before switching kind or leaving -32..31.
    assign run_break = cnt != 0 && (is_add(in_data) != kind || sum[6] != sum[5]);
    assign cmd_in    = in_data == CH_LB || in_data == CH_RB || in_data == CH_IN || in_data == CH_OUT;
    assign ovf       = prog_len[CADDR_WIDTH];
    assign patch     = state == PATCH_HI || state == PATCH_LO;
    assign fin       = last_r ? FINISH : ACCEPT;
    assign push      = state == OPEN_HI && code_wr;
    assign pop       = state == CLOSE && code_wr;

    always_ff @(posedge clk) begin
        if (reset) state <= ACCEPT;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ACCEPT:   if (accept) nstate = is_run(in_data) ? ((run_break || in_last) ? FLUSH : ACCEPT) :
                                           (cnt != 0 && (cmd_in || in_last)) ? FLUSH : target(in_data, in_last);
            FLUSH:    nstate = (cnt != 0 && ovf) ? ERROR : is_run(cur) ? (last_r ? FLUSH : ACCEPT) : target(cur, last_r);
            OPEN_HI:  nstate = (full || ovf) ? ERROR : OPEN_LO;
            OPEN_LO:  nstate = ovf ? ERROR : fin;
            CLOSE:    nstate = (empty || ovf) ? ERROR : PATCH_HI;
            PATCH_HI: nstate = PATCH_LO;
            PATCH_LO: nstate = fin;
            EMIT_IO:  nstate = ovf ? ERROR : fin;
            FINISH:   nstate = empty ? DONE : ERROR;
            default:  nstate = state;
        endcase
    end

    always_comb begin
        wr_req = 1'b0;
        addr   = prog_len[CADDR_WIDTH-1:0];
        data   = '0;
        case (state)
            FLUSH:    begin wr_req = cnt != 0; data = {kind ? OP_ADD : OP_MOVE, cnt}; end
            OPEN_HI:  begin wr_req = !full; data = {OP_LJ, 5'b0}; end
            OPEN_LO:  wr_req = 1'b1;
            CLOSE:    begin wr_req = !empty; data = OP_BR; end
            EMIT_IO:  begin wr_req = 1'b1; data = cur == CH_IN ? OP_IN : OP_OUT; end
            PATCH_HI: begin wr_req = 1'b1; addr = pa; data = {OP_LJ, 5'(poff >> 8)}; end
            PATCH_LO: begin wr_req = 1'b1; addr = pa + 1'b1; data = poff[7:0]; end
            default:  wr_req = 1'b0;
        endcase
    end

    assign code_wr    = wr_req && (patch || !ovf);
    assign code_waddr = code_wr ? addr : '0;
    assign code_wdata = code_wr ? data : '0;
    assign in_ready   = live && state == ACCEPT;
    assign done       = state == DONE;
    assign error      = state == ERROR;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= '0;
            last_r   <= 1'b0;
            cnt      <= '0;
            kind     <= 1'b0;
            live     <= 1'b0;
            pa       <= '0;
            poff     <= '0;
            err_code <= '0;
            prog_len <= '0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                last_r <= in_last;
                cur    <= (is_run(in_data) && !run_break) ? 8'h00 : in_data;
                if (is_run(in_data) && !run_break) begin
                    cnt  <= cnt + d_in;
                    kind <= is_add(in_data);
                end
            end
            // After the old run is out, a run byte that broke it starts the new count.
            if (state == FLUSH && nstate != ERROR) begin
                cnt  <= is_run(cur) ? run_delta(cur) : 6'sd0;
                kind <= is_add(cur);
                if (is_run(cur)) cur <= '0;
            end
            if (code_wr && !patch) prog_len <= prog_len + 1'b1;
            if (pop) begin
                pa   <= top;
                poff <= prog_len[CADDR_WIDTH-1:0] - top;
            end
            if (nstate == ERROR && state != ERROR)
                err_code <= (state == CLOSE && empty) ? ERR_UNMATCHED :
                            state == FINISH ? ERR_UNCLOSED : ERR_OVERFLOW;
        end
    end
endmodule

// File: tb/tb_bf_compiler.sv
// tb_bf_compiler: drives directed and random Brainfuck programs and compares every
// code write and the final status with a character-level compiler model.
module tb_bf_compiler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        code_wr;
    logic [12:0] code_waddr;
    logic [7:0]  code_wdata;
    logic        done, error;
    logic [1:0]  err_code;
    logic [13:0] prog_len;

    int errors = 0;
    int checks = 0;
    bit stopped;

    logic [7:0] src[$];
    int got_a[$], got_d[$], exp_a[$], exp_d[$];
    int m_cnt, m_len, m_ec, m_stk[$];
    bit m_kind, m_err, m_done;

    bf_compiler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .code_wr(code_wr), .code_waddr(code_waddr),
        .code_wdata(code_wdata), .done(done), .error(error), .err_code(err_code),
        .prog_len(prog_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_wr) begin
            got_a.push_back(int'(code_waddr));
            got_d.push_back(int'(code_wdata));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic m_emit(input int v);
        if (m_len >= 8192) begin
            m_err = 1;
            m_ec = 3;
        end else begin
            exp_a.push_back(m_len);
            exp_d.push_back(v);
            m_len++;
        end
    endtask

    task automatic m_flush();
        if (m_cnt != 0) m_emit((m_kind ? 'h40 : 'h00) | (m_cnt & 'h3F));
        m_cnt = 0;
    endtask

    task automatic model();
        logic [7:0] c;
        bit last, k;
        int d, a, r, off;
        m_cnt = 0; m_kind = 0; m_len = 0; m_ec = 0; m_err = 0; m_done = 0;
        m_stk.delete(); exp_a.delete(); exp_d.delete();
        for (int i = 0; i < src.size() && !m_err; i++) begin
            c = src[i];
            last = i == src.size() - 1;
            if (c == "+" || c == "-" || c == "<" || c == ">") begin
                d = (c == "+" || c == ">") ? 1 : -1;
                k = c == "+" || c == "-";
                if (m_cnt != 0 && (k != m_kind || m_cnt + d > 31 || m_cnt + d < -32)) m_flush();
                m_cnt += d;
                m_kind = k;
            end else if (c == "[" || c == "]" || c == "," || c == ".") begin
                m_flush();
                if (!m_err) begin
                    if (c == ",") m_emit('hC0);
                    else if (c == ".") m_emit('hE0);
                    else if (c == "[") begin
                        if (m_stk.size() == 16) begin m_err = 1; m_ec = 3; end
                        else begin
                            a = m_len;
                            m_emit('hA0);
                            if (!m_err) m_emit('h00);
                            if (!m_err) m_stk.push_back(a);
                        end
                    end else begin
                        if (m_stk.size() == 0) begin m_err = 1; m_ec = 1; end
                        else begin
                            r = m_len;
                            m_emit('h80);
                            if (!m_err) begin
                                a = m_stk.pop_back();
                                off = (r - a) & 'h1FFF;
                                exp_a.push_back(a);
                                exp_d.push_back('hA0 | (off >> 8));
                                exp_a.push_back(a + 1);
                                exp_d.push_back(off & 'hFF);
                            end
                        end
                    end
                end
            end
            if (last && !m_err) begin
                m_flush();
                if (!m_err) begin
                    if (m_stk.size() != 0) begin m_err = 1; m_ec = 2; end
                    else m_done = 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; in_valid = 0; in_last = 0;
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        got_a.delete();
        got_d.delete();
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        in_valid = 1; in_data = b; in_last = last;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 0; in_last = 0;
                return;
            end
            if (done || error) begin
                stopped = 1; in_valid = 0; in_last = 0;
                @(posedge clk); #1;
                return;
            end
        end
        check("send_timeout", {31'b0, in_ready}, 1);
        stopped = 1; in_valid = 0; in_last = 0;
        @(posedge clk); #1;
    endtask

    task automatic set_src(input string s);
        src.delete();
        for (int i = 0; i < s.len(); i++) src.push_back(s[i]);
    endtask

    function automatic logic [31:0] got_at(input bit data_q, input int idx);
        if (idx >= got_a.size()) return 'x;
        return data_q ? got_d[idx] : got_a[idx];
    endfunction

    task automatic run_prog(input string tag);
        do_reset();
        model();
        stopped = 0;
        for (int i = 0; i < src.size() && !stopped; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(src[i], i == src.size() - 1);
        end
        for (int t = 0; t < 400 && !(done || error); t++) @(negedge clk);
        check({tag, "/ended"}, {31'b0, done | error}, 1);
        check({tag, "/nwr"}, got_a.size(), exp_a.size());
        for (int j = 0; j < exp_a.size(); j++) begin
            check($sformatf("%s/wa%0d", tag, j), got_at(0, j), exp_a[j]);
            check($sformatf("%s/wd%0d", tag, j), got_at(1, j), exp_d[j]);
        end
        check({tag, "/done"}, {31'b0, done}, {31'b0, m_done});
        check({tag, "/error"}, {31'b0, error}, {31'b0, m_err});
        check({tag, "/err_code"}, {30'b0, err_code}, m_ec);
        check({tag, "/prog_len"}, {18'b0, prog_len}, m_len);
        check({tag, "/ready"}, {31'b0, in_ready}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/in_ready"}, {31'b0, in_ready}, 0);
        check({tag, "/code_wr"}, {31'b0, code_wr}, 0);
        check({tag, "/waddr"}, {19'b0, code_waddr}, 0);
        check({tag, "/wdata"}, {24'b0, code_wdata}, 0);
        check({tag, "/done"}, {31'b0, done}, 0);
        check({tag, "/error"}, {31'b0, error}, 0);
        check({tag, "/err_code"}, {30'b0, err_code}, 0);
        check({tag, "/prog_len"}, {18'b0, prog_len}, 0);
    endtask

    initial begin
        string alpha;
        string s;
        int n;
        alpha = "+-<>[],.x";

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("rst/ready_hold", {31'b0, in_ready}, 0);
        @(negedge clk);
        check("rst/ready_rise", {31'b0, in_ready}, 1);

        set_src("+++");
        run_prog("plus3");
        check("plus3/d0", got_at(1, 0), 'h43);

        set_src("-->><");
        run_prog("mix");
        check("mix/d0", got_at(1, 0), 'h7E);
        check("mix/d1", got_at(1, 1), 'h01);

        s = "";
        for (int i = 0; i < 33; i++) s = {s, "+"};
        set_src(s);
        run_prog("plus33");
        check("plus33/d0", got_at(1, 0), 'h5F);
        check("plus33/d1", got_at(1, 1), 'h42);
        set_src({s, "<"});
        run_prog("plus33lt");
        check("plus33lt/d2", got_at(1, 2), 'h3F);

        set_src("+a-");
        run_prog("netzero");
        check("netzero/len", {18'b0, prog_len}, 0);

        set_src("[-]");
        run_prog("loop");
        check("loop/d2", got_at(1, 2), 'h7F);
        check("loop/patch_a", got_at(0, 5), 1);
        check("loop/patch_d", got_at(1, 5), 'h03);

        set_src("[[]]");
        run_prog("nest");
        check("nest/inner_off", got_at(1, 6), 'h02);

        set_src(",.x.,");
        run_prog("io");

        set_src("]");
        run_prog("unmatched");
        check("unmatched/code", {30'b0, err_code}, 1);

        set_src("[");
        run_prog("unclosed");
        check("unclosed/code", {30'b0, err_code}, 2);

        s = "";
        for (int i = 0; i < 17; i++) s = {s, "["};
        set_src(s);
        run_prog("deep");
        check("deep/code", {30'b0, err_code}, 3);

        do_reset();
        send("[", 0);
        @(negedge clk);
        check("midrst/first_wr", {31'b0, code_wr}, 1);
        check("midrst/first_d", {24'b0, code_wdata}, 'hA0);
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset = 0;

        for (int p = 0; p < 30; p++) begin
            src.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                logic [7:0] c;
                c = alpha[$urandom_range(0, 8)];
                repeat ($urandom_range(1, (c == "[" || c == "]") ? 2 : 20)) src.push_back(c);
            end
            run_prog($sformatf("rnd%0d", p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
